// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: start, data (LSB first), optional parity and stop bits.
// Host side is a valid/ready handshake; line side is a registered tx_o that idles high.
module uart_tx_ctrl #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_BITS    = 8,
  parameter bit          PARITY_EN    = 1'b0,
  parameter bit          PARITY_ODD   = 1'b0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [DATA_BITS-1:0] tx_data_i,
  input  logic                 tx_valid_i,
  output logic                 tx_ready_o,
  output logic                 tx_o,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int unsigned BaudW = 16;
  localparam int unsigned BitW  = 4;

  localparam logic [BaudW-1:0] BaudLast  = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [BitW-1:0]  StartLast = BitW'(0);
  localparam logic [BitW-1:0]  DataLast  = BitW'(DATA_BITS - 1);
  localparam logic [BitW-1:0]  ParLast   = BitW'(0);
  localparam logic [BitW-1:0]  StopLast  = BitW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [BaudW-1:0]     baud_q, baud_d;
  logic [BitW-1:0]      bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 parity_q, parity_d;
  logic                 tx_q, tx_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 accept;
  logic                 bit_end;
  logic [BitW-1:0]      phase_last;
  logic                 phase_done;

  assign accept     = tx_valid_i && ready_q;
  assign bit_end    = (state_q != S_IDLE) && (baud_q == BaudLast);
  assign phase_done = bit_end && (bit_q == phase_last);

  // Index of the final bit in the current phase
  always_comb begin
    phase_last = StartLast;
    case (state_q)
      S_START:  phase_last = StartLast;
      S_DATA:   phase_last = DataLast;
      S_PARITY: phase_last = ParLast;
      S_STOP:   phase_last = StopLast;
      default:  phase_last = StartLast;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    parity_d = parity_q;

    if (state_q != S_IDLE) begin
      baud_d = bit_end ? '0 : baud_q + BaudW'(1);
      if (bit_end) begin
        bit_d = bit_q + BitW'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d  = S_START;
          shreg_d  = tx_data_i;
          parity_d = (^tx_data_i) ^ PARITY_ODD;
          baud_d   = '0;
        end
      end
      S_START: begin
        if (phase_done) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shreg_d = shreg_q >> 1;
        end
        if (phase_done) begin
          state_d = PARITY_EN ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (phase_done) begin
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (phase_done) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Bit counter restarts at every phase boundary
    if (state_d != state_q) begin
      bit_d = '0;
    end

    // Outputs are registered from next-state values so they line up with the state they describe
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shreg_d[0];
      S_PARITY: tx_d = parity_d;
      default:  tx_d = 1'b1;
    endcase
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_STOP) && (baud_d == BaudLast) && (bit_d == StopLast);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign tx_o       = tx_q;
  assign tx_ready_o = ready_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule
